// File: rtl/text_console_if.sv
// text_console_if: console byte stream in, framebuffer write port and cursor/scroll state out
interface text_console_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [11:0] in_fg;
    logic [11:0] in_bg;
    logic        clear;
    logic [7:0]  write_posx;
    logic [5:0]  write_posy;
    logic [31:0] write_value;
    logic        write_enable;
    logic [5:0]  v_offset;
    logic [7:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;
    modport master (
        output in_valid, in_char, in_fg, in_bg, clear,
        input  in_ready, write_posx, write_posy, write_value, write_enable,
        input  v_offset, cursor_x, cursor_y, busy
    );
    modport slave (
        input  in_valid, in_char, in_fg, in_bg, clear,
        output in_ready, write_posx, write_posy, write_value, write_enable,
        output v_offset, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns a console byte stream into framebuffer cell writes,
// tracking cursor, hardware scroll offset, line clears on scroll and full-screen clears.
module text_console_ctrl #(
    parameter int          COLS   = 160,
    parameter int          ROWS   = 45,
    parameter logic [11:0] FG_RST = 12'hFFF,
    parameter logic [11:0] BG_RST = 12'h000
) (
    input  logic clk,
    input  logic rst,
    text_console_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_ALL} state_t;
    localparam logic [7:0] LAST_X = 8'(COLS - 1);
    localparam logic [7:0] NCOLS  = 8'(COLS);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);
    localparam logic [6:0] NROWS  = 7'(ROWS);
    localparam logic [7:0] BLANK  = 8'h20;
    state_t      state, state_n;
    logic [7:0]  cx, cx_n, cnt_x, cnt_x_n, px, px_n;
    logic [5:0]  cy, cy_n, voff, voff_n, cnt_y, cnt_y_n, py, py_n, phys_y;
    logic [11:0] fg, fg_n, bg, bg_n;
    logic [31:0] val, val_n;
    logic [6:0]  sum;
    logic        we, we_n, ready, nl;
    assign ready            = state == IDLE;
    assign bus.in_ready     = ready;
    assign bus.busy         = ~ready;
    assign bus.write_posx   = px;
    assign bus.write_posy   = py;
    assign bus.write_value  = val;
    assign bus.write_enable = we;
    assign bus.v_offset     = voff;
    assign bus.cursor_x     = cx;
    assign bus.cursor_y     = cy;
    // logical row -> physical row with a single conditional subtract
    assign sum    = {1'b0, cy} + {1'b0, voff};
    assign phys_y = sum >= NROWS ? 6'(sum - NROWS) : sum[5:0];
    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        voff_n  = voff;
        fg_n    = fg;
        bg_n    = bg;
        cnt_x_n = cnt_x;
        cnt_y_n = cnt_y;
        we_n    = 1'b0;
        px_n    = px;
        py_n    = py;
        val_n   = val;
        nl      = 1'b0;
        if (bus.clear) begin
            state_n = CLR_ALL;
            cnt_x_n = '0;
            cnt_y_n = '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    fg_n = bus.in_fg;
                    bg_n = bus.in_bg;
                    if (bus.in_char == 8'h0D) cx_n = '0;
                    else if (bus.in_char == 8'h08) cx_n = cx != '0 ? cx - 8'd1 : cx;
                    else if (bus.in_char == 8'h0A) nl = 1'b1;
                    else begin
                        we_n  = 1'b1;
                        px_n  = cx;
                        py_n  = phys_y;
                        val_n = {bus.in_fg, bus.in_bg, bus.in_char};
                        cx_n  = cx + 8'd1;
                        nl    = cx == LAST_X;
                    end
                    if (nl) begin
                        cx_n = '0;
                        // bottom row: recycle the old top row as the new bottom
                        if (cy < LAST_Y) cy_n = cy + 6'd1;
                        else begin
                            state_n = CLR_LINE;
                            cnt_x_n = '0;
                        end
                    end
                end
                CLR_LINE: if (cnt_x < NCOLS) begin
                    we_n    = 1'b1;
                    px_n    = cnt_x;
                    py_n    = voff;
                    val_n   = {fg, bg, BLANK};
                    cnt_x_n = cnt_x + 8'd1;
                end else begin
                    voff_n  = voff == LAST_Y ? '0 : voff + 6'd1;
                    state_n = IDLE;
                end
                CLR_ALL: begin
                    we_n    = 1'b1;
                    px_n    = cnt_x;
                    py_n    = cnt_y;
                    val_n   = {fg, bg, BLANK};
                    cnt_x_n = cnt_x == LAST_X ? '0 : cnt_x + 8'd1;
                    cnt_y_n = cnt_x == LAST_X ? cnt_y + 6'd1 : cnt_y;
                    if (cnt_x == LAST_X && cnt_y == LAST_Y) begin
                        state_n = IDLE;
                        cnt_y_n = '0;
                        cx_n    = '0;
                        cy_n    = '0;
                        voff_n  = '0;
                    end
                end
                default: begin
                    state_n = CLR_ALL;
                    cnt_x_n = '0;
                    cnt_y_n = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLR_ALL;
            cx    <= '0;
            cy    <= '0;
            voff  <= '0;
            fg    <= FG_RST;
            bg    <= BG_RST;
            cnt_x <= '0;
            cnt_y <= '0;
            we    <= 1'b0;
            px    <= '0;
            py    <= '0;
            val   <= '0;
        end else begin
            state <= state_n;
            cx    <= cx_n;
            cy    <= cy_n;
            voff  <= voff_n;
            fg    <= fg_n;
            bg    <= bg_n;
            cnt_x <= cnt_x_n;
            cnt_y <= cnt_y_n;
            we    <= we_n;
            px    <= px_n;
            py    <= py_n;
            val   <= val_n;
        end
    end
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb_text_console_ctrl: randomized console traffic against a screen-level model;
// expected framebuffer writes are queued and a separate monitor checks every strobe.
module tb_text_console_ctrl;
    localparam int COLS = 160;
    localparam int ROWS = 45;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    logic [45:0] exp_q[$];
    int mx = 0, my = 0, mvo = 0;
    logic [11:0] m_fg = 12'hFFF, m_bg = 12'h000;
    text_console_if bus();
    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .FG_RST(12'hFFF), .BG_RST(12'h000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic void push_w(int x, int y, logic [31:0] v);
        exp_q.push_back({8'(x), 6'(y), v});
    endfunction
    function automatic void push_clear_all();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) push_w(x, y, {m_fg, m_bg, 8'h20});
        mx = 0;
        my = 0;
        mvo = 0;
    endfunction
    function automatic void model_newline();
        mx = 0;
        if (my < ROWS - 1) my++;
        else begin
            for (int x = 0; x < COLS; x++) push_w(x, mvo, {m_fg, m_bg, 8'h20});
            mvo = (mvo + 1) % ROWS;
        end
    endfunction
    function automatic void model_char(logic [7:0] c, logic [11:0] fg, logic [11:0] bg);
        m_fg = fg;
        m_bg = bg;
        if (c == 8'h0D) mx = 0;
        else if (c == 8'h08) begin
            if (mx > 0) mx--;
        end else if (c == 8'h0A) model_newline();
        else begin
            push_w(mx, (my + mvo) % ROWS, {fg, bg, c});
            if (mx == COLS - 1) model_newline();
            else mx++;
        end
    endfunction
    // monitor: every strobe must match the oldest outstanding expected write
    initial begin
        logic [45:0] e;
        forever begin
            @(negedge clk);
            if (bus.write_enable) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected got x=%0d y=%0d v=%h, expected no write",
                             bus.write_posx, bus.write_posy, bus.write_value);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.write_posx, bus.write_posy, bus.write_value} !== e) begin
                        errors++;
                        $display("FAIL write got x=%0d y=%0d v=%h, expected x=%0d y=%0d v=%h",
                                 bus.write_posx, bus.write_posy, bus.write_value,
                                 e[45:38], e[37:32], e[31:0]);
                    end
                end
            end
        end
    end
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.in_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            errors++;
            checks++;
            $display("FAIL wait_ready got timeout after %0d cycles, expected in_ready", n);
        end
    endtask
    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask
    task automatic send(logic [7:0] c, logic [11:0] fg, logic [11:0] bg);
        int n;
        wait_ready(n);
        bus.in_char = c;
        bus.in_fg = fg;
        bus.in_bg = bg;
        bus.in_valid = 1'b1;
        model_char(c, fg, bg);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    task automatic check_state(string name);
        int n;
        wait_ready(n);
        chk({name, ".cursor_x"}, int'(bus.cursor_x), mx);
        chk({name, ".cursor_y"}, int'(bus.cursor_y), my);
        chk({name, ".v_offset"}, int'(bus.v_offset), mvo);
        chk({name, ".busy"}, int'(bus.busy), 0);
    endtask
    // clear pulse with a character held on in_valid; the character lands after the clear
    task automatic clear_hold(logic [7:0] c, logic [11:0] fg, logic [11:0] bg);
        int n;
        bus.clear = 1'b1;
        bus.in_char = c;
        bus.in_fg = fg;
        bus.in_bg = bg;
        bus.in_valid = 1'b1;
        push_clear_all();
        model_char(c, fg, bg);
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_busy", int'(bus.busy), 1);
        wait_ready(n);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    function automatic logic [7:0] rand_print();
        logic [7:0] c = 8'($urandom_range(0, 255));
        return (c == 8'h08 || c == 8'h0A || c == 8'h0D) ? 8'h2A : c;
    endfunction
    initial begin
        int n;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char = '0;
        bus.in_fg = '0;
        bus.in_bg = '0;
        bus.clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.write_enable", int'(bus.write_enable), 0);
        chk("rst.write_value", int'(bus.write_value), 0);
        chk("rst.posx", int'(bus.write_posx), 0);
        chk("rst.v_offset", int'(bus.v_offset), 0);
        chk("rst.cursor", int'({bus.cursor_x, bus.cursor_y}), 0);
        chk("rst.busy", int'(bus.busy), 1);
        push_clear_all();
        rst = 1'b0;
        wait_ready(n);
        chk("init_busy_cycles", n, ROWS * COLS);
        check_state("init");
        send(8'h41, 12'hF00, 12'h00F);
        check_state("char_A");
        send(8'h0D, 12'h0F0, 12'h000);
        for (int i = 0; i < 161; i++) send(rand_print(), 12'($urandom), 12'($urandom));
        check_state("wrap");
        send(8'h0D, 12'hFFF, 12'h000);
        for (int i = 0; i < 43; i++) send(8'h0A, 12'h123, 12'h456);
        for (int i = 0; i < 5; i++) send(rand_print(), 12'hAAA, 12'h555);
        check_state("row44");
        send(8'h0A, 12'h789, 12'hABC);
        check_state("scroll1");
        send(8'h42, 12'h0FF, 12'hF0F);
        for (int i = 0; i < 45; i++) send(8'h0A, 12'($urandom), 12'($urandom));
        check_state("scroll_wrap");
        send(8'h0D, 12'h111, 12'h222);
        send(8'h08, 12'h111, 12'h222);
        check_state("bs_at_0");
        clear_hold(8'h43, 12'hF0F, 12'h0F0);
        check_state("clear_idle");
        send(8'h0D, 12'h333, 12'h444);
        for (int i = 0; i < 3; i++) send(8'h0A, 12'h333, 12'h444);
        for (int i = 0; i < 37; i++) send(rand_print(), 12'($urandom), 12'($urandom));
        check_state("at_37_3");
        send(8'h0D, 12'h555, 12'h666);
        check_state("cr");
        for (int i = 0; i < 41; i++) send(8'h0A, 12'h777, 12'h888);
        check_state("row44_again");
        // start a line clear by hand and abort it with clear after 50 writes
        wait_ready(n);
        bus.in_char = 8'h0A;
        bus.in_fg = 12'hE1E;
        bus.in_bg = 12'h2D2;
        bus.in_valid = 1'b1;
        m_fg = 12'hE1E;
        m_bg = 12'h2D2;
        mx = 0;
        for (int x = 0; x < 50; x++) push_w(x, mvo, {m_fg, m_bg, 8'h20});
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (50) @(negedge clk);
        clear_hold(8'h44, 12'h0F0, 12'h00F);
        check_state("clear_mid_line");
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 9);
            logic [7:0] c = r < 2 ? 8'h0A : r == 2 ? 8'h0D : r == 3 ? 8'h08 : rand_print();
            send(c, 12'($urandom), 12'($urandom));
            if (i % 25 == 0) check_state("random");
        end
        check_state("final");
        repeat (5) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
